mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one shift-add multiplier among NREQ requesters. Accepts one operand pair at a time and drives the multiplier's start and operand inputs. Waits for completion, then returns the product tagged with the requester index. Sits between the requesting datapath blocks and the single multiplier instance.

---
 rtl/mult_arb_pkg.sv | 17 +
 rtl/mult_arbiter_rr_grant.sv | 45 ++++
 rtl/mult_arbiter.sv | 116 +++++++++++
 tb/tb_mult_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier arbiter: one-hot FSM state encoding and
// the requester-index width helper.
package mult_arb_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_grant.sv
// Combinational winner select for the multiplier arbiter. Round-robin from
// ptr by default; MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module rr_grant
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  int base;

`ifdef MULT_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = 0;
`else
  assign base = int'(ptr);
`endif

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a variable unassigned, which would infer a latch.
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    // First asserted request searching upward from base, wrapping at NREQ-1.
    for (int i = 0; i < NREQ; i++) begin
      idx = (base + i) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier among NREQ requesters: grant, issue, wait
// for mul_done, return the tagged product. MULT_ARB_FIXED_PRIO_EN -> fixed priority.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              mul_start,
  output logic [N-1:0]      mul_multiplicand,
  output logic [N-1:0]      mul_multiplier,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_product,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [2*N-1:0]   prod_q, prod_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          id_d    = grant_id;
          a_d     = req_a[int'(grant_id)*N +: N];
          b_d     = req_b[int'(grant_id)*N +: N];
          state_d = ISSUE;
        end
      end
      // mul_done is deliberately not looked at here: the multiplier has not started yet.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = RESP;
        end
      end
      RESP: begin
`ifdef MULT_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = (int'(id_q) == NREQ-1) ? '0 : id_q + 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high; it is just the highest-priority
  // branch of the clocked process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // No handshake can complete while reset is wiping the operand latches.
  assign req_ready        = (state_q == IDLE && !rst) ? grant : '0;
  assign mul_start        = (state_q == ISSUE);
  assign rsp_valid        = (state_q == RESP);
  assign busy             = (state_q != IDLE);
  assign rsp_id           = id_q;
  assign rsp_product      = prod_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, corner-case
// sequences, then randomized traffic against a transaction-level model.
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [15:0] req_a, req_b;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_product;
  logic       mul_start;
  logic [3:0] mul_multiplicand, mul_multiplier;
  logic       mul_done;
  logic [7:0] mul_product;
  logic       busy;

  int tests = 0;
  int fails = 0;

  mult_arbiter #(.N(4), .NREQ(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    mul_done  = 1'b0;
    mul_product = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input int a, input int b);
    logic [3:0] a4, b4;
    a4 = 4'(a);
    b4 = 4'(b);
    req_a[id*4 +: 4] = a4;
    req_b[id*4 +: 4] = b4;
    req_valid[id]    = 1'b1;
  endtask

  // One complete transaction starting in the current IDLE cycle; ends in the IDLE cycle after RESP.
  task automatic txn(input int id, input int lat, input int prod, input bit keep,
                     input logic [3:0] drop, input bit stray);
    logic [3:0] ea, eb;
    #1;
    ea = req_a[id*4 +: 4];
    eb = req_b[id*4 +: 4];
    check("grant", req_ready, 32'(1) << id);
    check("idle_busy", busy, 0);
    tick;
    if (!keep) req_valid[id] = 1'b0;
    req_valid   = req_valid & ~drop;
    mul_done    = stray;
    mul_product = 8'h5A;
    #1;
    check("issue_start", mul_start, 1);
    check("issue_op_a", mul_multiplicand, ea);
    check("issue_op_b", mul_multiplier, eb);
    check("issue_busy", busy, 1);
    check("issue_ready", req_ready, 0);
    for (int j = 1; j <= lat; j++) begin
      tick;
      mul_done    = (j == lat);
      mul_product = {4'b0, mul_multiplicand} * {4'b0, mul_multiplier};
      #1;
      check("wait_rsp", rsp_valid, 0);
      check("wait_start", mul_start, 0);
      check("wait_busy", busy, 1);
      check("wait_ready", req_ready, 0);
    end
    tick;
    mul_done    = 1'b0;
    mul_product = 8'h00;
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_product", rsp_product, prod);
    check("rsp_busy", busy, 1);
    check("rsp_hold_a", mul_multiplicand, ea);
    check("rsp_hold_b", mul_multiplier, eb);
    tick;
    #1;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
  endtask

  // Spec rule: first asserted request searching upward from ptr, wrapping.
  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic int next_ptr(input int id);
`ifdef MULT_ARB_FIXED_PRIO_EN
    return 0 * id;
`else
    return (id + 1) % 4;
`endif
  endfunction

  typedef struct {
    int id;
    int a;
    int b;
    int lat;
    int prod;
  } vec_t;

  vec_t vecs[6];
  int   order[5];

  // Random-phase model state.
  bit         m_free;
  int         m_ptr, m_acc, m_done, m_id, w;
  logic [3:0] m_a, m_b;
  logic [7:0] e_prod;
  logic [3:0] pend;
  logic [3:0] pa[4], pb[4];
  logic [3:0] exp_ready;
  bit         exp_start, exp_rsp, stray_ok;

  initial begin
    vecs[0] = '{id: 2, a: 5,  b: 3,  lat: 2, prod: 15};
    vecs[1] = '{id: 0, a: 15, b: 15, lat: 1, prod: 225};
    vecs[2] = '{id: 1, a: 0,  b: 9,  lat: 4, prod: 0};
    vecs[3] = '{id: 3, a: 7,  b: 0,  lat: 3, prod: 0};
    vecs[4] = '{id: 2, a: 15, b: 1,  lat: 1, prod: 15};
    vecs[5] = '{id: 1, a: 12, b: 11, lat: 2, prod: 132};
`ifdef MULT_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif

    // Reset state.
    do_reset;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_op_a", mul_multiplicand, 0);
    check("rst_op_b", mul_multiplier, 0);
    check("rst_busy", busy, 0);

    // Single-requester vectors, including operand extremes.
    for (int v = 0; v < 6; v++) begin
      do_reset;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      txn(vecs[v].id, vecs[v].lat, vecs[v].prod, 1'b0, 4'b0, 1'b0);
    end

    // All four requesting continuously from reset.
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 2*i + 1, 2*i + 2);
    for (int k = 0; k < 5; k++)
      txn(order[k], 2, (2*order[k] + 1) * (2*order[k] + 2), 1'b1, 4'b0, 1'b0);

    // Stray mul_done in IDLE, then early mul_done in ISSUE.
    do_reset;
    tick;
    mul_done = 1'b1;
    mul_product = 8'hAA;
    #1;
    check("stray_idle_busy", busy, 0);
    tick;
    mul_done = 1'b0;
    #1;
    check("stray_idle_rsp", rsp_valid, 0);
    check("stray_idle_busy2", busy, 0);
    set_req(1, 3, 5);
    txn(1, 3, 15, 1'b0, 4'b0, 1'b1);

    // Reset during WAIT drops the request; pointer returns to 0.
    do_reset;
    set_req(2, 4, 4);
    txn(2, 1, 16, 1'b0, 4'b0, 1'b0);
    set_req(2, 6, 7);
    #1;
    check("rw_grant", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    #1;
    check("rw_start", mul_start, 1);
    tick;
    #1;
    check("rw_wait_busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("rw_ready", req_ready, 0);
    check("rw_rsp_valid", rsp_valid, 0);
    check("rw_rsp_id", rsp_id, 0);
    check("rw_rsp_product", rsp_product, 0);
    check("rw_mul_start", mul_start, 0);
    check("rw_op_a", mul_multiplicand, 0);
    check("rw_op_b", mul_multiplier, 0);
    check("rw_busy", busy, 0);
    tick;
    mul_done = 1'b1;
    mul_product = 8'd42;
    #1;
    check("rw_late_done_rsp", rsp_valid, 0);
    tick;
    mul_done = 1'b0;
    #1;
    check("rw_late_done_rsp2", rsp_valid, 0);
    check("rw_late_done_busy", busy, 0);
    set_req(1, 2, 3);
    set_req(3, 9, 9);
    txn(1, 2, 6, 1'b0, 4'b0, 1'b0);
    txn(3, 1, 81, 1'b0, 4'b0, 1'b0);

    // Withdrawn request while another is served.
    do_reset;
    set_req(2, 1, 2);
    txn(2, 1, 2, 1'b0, 4'b0, 1'b0);
    set_req(3, 5, 5);
    set_req(1, 4, 2);
`ifdef MULT_ARB_FIXED_PRIO_EN
    txn(1, 2, 8, 1'b0, 4'b1000, 1'b0);
`else
    txn(3, 2, 25, 1'b0, 4'b0010, 1'b0);
`endif
    set_req(0, 3, 3);
    set_req(2, 2, 2);
    txn(0, 1, 9, 1'b0, 4'b0, 1'b0);
    txn(2, 1, 4, 1'b0, 4'b0, 1'b0);

    // Randomized traffic against the transaction-level model.
    do_reset;
    pend   = '0;
    m_free = 1'b1;
    m_ptr  = 0;
    m_acc  = -10;
    m_done = -1;
    m_id   = 0;
    m_a    = '0;
    m_b    = '0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4) begin
          pend[i] = 1'b1;
          pa[i]   = 4'($urandom_range(0, 15));
          pb[i]   = 4'($urandom_range(0, 15));
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[i]     = pend[i];
        req_a[i*4 +: 4]  = pa[i];
        req_b[i*4 +: 4]  = pb[i];
      end
      // Stray pulses only where the arbiter must ignore them: free, ISSUE or RESP.
      stray_ok = m_free || (c == m_acc + 1) || (m_done >= 0 && c == m_done + 1);
      if (c == m_done) begin
        mul_done    = 1'b1;
        mul_product = {4'b0, m_a} * {4'b0, m_b};
      end else begin
        mul_done    = stray_ok && ($urandom_range(0, 9) == 0);
        mul_product = 8'($urandom);
      end
      #1;
      exp_ready = '0;
      w = -1;
      if (m_free) begin
        w = rr_pick(req_valid, m_ptr);
        if (w >= 0) exp_ready = 4'(32'(1) << w);
      end
      exp_start = !m_free && (c == m_acc + 1);
      exp_rsp   = !m_free && m_done >= 0 && (c == m_done + 1);
      check("rnd_ready", req_ready, exp_ready);
      check("rnd_start", mul_start, exp_start);
      check("rnd_rsp_valid", rsp_valid, exp_rsp);
      check("rnd_busy", busy, !m_free);
      if (exp_start) begin
        check("rnd_op_a", mul_multiplicand, m_a);
        check("rnd_op_b", mul_multiplier, m_b);
        m_done = c + $urandom_range(1, 5);
      end
      if (exp_rsp) begin
        e_prod = {4'b0, m_a} * {4'b0, m_b};
        check("rnd_rsp_id", rsp_id, m_id);
        check("rnd_rsp_product", rsp_product, e_prod);
        m_ptr  = next_ptr(m_id);
        m_free = 1'b1;
        m_done = -1;
      end else if (w >= 0) begin
        m_free  = 1'b0;
        m_acc   = c;
        m_id    = w;
        m_a     = pa[w];
        m_b     = pb[w];
        pend[w] = 1'b0;
        m_done  = -1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
